// File: rtl/lcd_refresh_ctrl_if.sv
// rtl/lcd_refresh_ctrl_if.sv - HD44780 8-bit LCD pin bundle
interface lcd_refresh_ctrl_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
    modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - HD44780 16x2 init and two-row refresh sequencer
module lcd_refresh_ctrl #(
    parameter int INIT_WAIT   = 200000,
    parameter int EN_CYCLES   = 5,
    parameter int WAIT_CYCLES = 500,
    parameter int CLR_WAIT    = 20000
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic [127:0]               row1,
    input  logic [127:0]               row2,
    input  logic                       update,
    lcd_refresh_ctrl_if.master         lcd,
    output logic                       lcd_on,
    output logic                       busy
);
    localparam int MAX_A = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int MAX_B = (WAIT_CYCLES > EN_CYCLES) ? WAIT_CYCLES : EN_CYCLES;
    localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXW + 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR1, ROW1, ADDR2, ROW2, IDLE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [7:0]      snap_q [32];
    logic            rs_q, rs_d, en_q, en_d, on_q, on_d, busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic            start_refresh;
    logic            byte_done;

    // State, counters, snapshot buffer and registered pin outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= PWR_WAIT;
            phase_q   <= PH_SETUP;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= 8'h00;
            on_q      <= 1'b0;
            busy_q    <= 1'b1;
            for (int i = 0; i < 32; i++) snap_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            data_q    <= data_d;
            on_q      <= on_d;
            busy_q    <= busy_d;
            if (start_refresh) begin
                for (int i = 0; i < 16; i++) begin
                    snap_q[i]      <= row1[127-8*i -: 8];
                    snap_q[i + 16] <= row2[127-8*i -: 8];
                end
            end
        end
    end

    // Next-state sequencing and next values for the registered outputs
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pending_d     = pending_q | (update && (state_q != IDLE));
        start_refresh = 1'b0;
        byte_done     = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == CW'(INIT_WAIT - 1)) begin
                    state_d = INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (update) start_refresh = 1'b1;
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_EN;
                        cnt_d   = CW'(EN_CYCLES - 1);
                    end
                    PH_EN: begin
                        if (cnt_q == '0) begin
                            phase_d = PH_WAIT;
                            // The clear command needs a much longer execution time
                            cnt_d   = (state_q == INIT && idx_q == 4'd3) ? CW'(CLR_WAIT - 1)
                                                                       : CW'(WAIT_CYCLES - 1);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == '0) byte_done = 1'b1;
                        else             cnt_d = cnt_q - CW'(1);
                    end
                endcase
            end
        endcase

        if (byte_done) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            idx_d   = idx_q + 4'd1;
            case (state_q)
                INIT:  if (idx_q == 4'd3) start_refresh = 1'b1;
                ADDR1: begin state_d = ROW1; idx_d = '0; end
                ROW1:  if (idx_q == 4'hF) state_d = ADDR2;
                ADDR2: begin state_d = ROW2; idx_d = '0; end
                ROW2: begin
                    if (idx_q == 4'hF) begin
                        // A request seen during this refresh chains straight into the next one
                        if (pending_q || update) start_refresh = 1'b1;
                        else                     state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (start_refresh) begin
            state_d   = ADDR1;
            phase_d   = PH_SETUP;
            cnt_d     = '0;
            idx_d     = '0;
            pending_d = 1'b0;
        end

        en_d   = (state_d != IDLE) && (state_d != PWR_WAIT) && (phase_d == PH_EN);
        rs_d   = rs_q;
        data_d = data_q;
        case (state_d)
            INIT: begin
                rs_d = 1'b0;
                case (idx_d)
                    4'd0:    data_d = 8'h38;
                    4'd1:    data_d = 8'h0C;
                    4'd2:    data_d = 8'h06;
                    default: data_d = 8'h01;
                endcase
            end
            ADDR1: begin rs_d = 1'b0; data_d = 8'h80; end
            ROW1:  begin rs_d = 1'b1; data_d = snap_q[{1'b0, idx_d}]; end
            ADDR2: begin rs_d = 1'b0; data_d = 8'hC0; end
            ROW2:  begin rs_d = 1'b1; data_d = snap_q[{1'b1, idx_d}]; end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        on_d   = on_q | (state_d == ADDR1);
    end

    assign lcd.lcd_rs   = rs_q;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_en   = en_q;
    assign lcd.lcd_data = data_q;
    assign lcd_on       = on_q;
    assign busy         = busy_q;
endmodule
